sim_score_streamer: RTL

- Producer end of the similarity-score stream consumed by StreamMax.
- For each image vector i (0..IMG_VEC_N-1), walks every library vector j (0..LIB_VEC_N-1) and emits one beat per pair.
- Each beat carries out_data = popcount(~(img ^ lib)) (matching bits) and norm_data = popcount(lib).
- Marks the last beat of each row with inner_done, then emits a single outer_done beat after the last row.
- Vectors are read from two synchronous-read memories, each with 1-cycle read latency.

---
 rtl/sim_score_streamer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sim_score_streamer.sv
// Similarity-score producer: for every image row, walks the library vectors and
// streams match-count / library-popcount beats, then one end-of-pass marker.
//
// state | meaning
// IDLE  | waiting for start
// IMG_A | image memory samples img_addr
// IMG_D | image data returned, latch into img_reg
// LIB_A | library memory samples lib_addr
// LIB_D | library data returned, compute and register beat
// SEND  | beat presented, waiting for nest_ready
// OUTER | outer_done presented, waiting for nest_ready
module sim_score_streamer #(
  parameter int IMG_VEC_N = 3,
  parameter int LIB_VEC_N = 5,
  parameter int VEC_WIDTH = 48,
  parameter int SW        = $clog2(VEC_WIDTH + 1),
  parameter int IAW       = (IMG_VEC_N > 1) ? $clog2(IMG_VEC_N) : 1,
  parameter int LAW       = (LIB_VEC_N > 1) ? $clog2(LIB_VEC_N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IAW-1:0]       img_addr,
  input  logic [VEC_WIDTH-1:0] img_rdata,
  output logic [LAW-1:0]       lib_addr,
  input  logic [VEC_WIDTH-1:0] lib_rdata,
  output logic                 out_valid,
  input  logic                 nest_ready,
  output logic [SW-1:0]        out_data,
  output logic [SW-1:0]        norm_data,
  output logic                 inner_done,
  output logic                 indone_valid,
  output logic                 outer_done,
  output logic                 outdone_valid
);

  typedef enum logic [2:0] {
    IDLE, IMG_A, IMG_D, LIB_A, LIB_D, SEND, OUTER
  } state_t;

  localparam logic [IAW-1:0] ROW_LAST = IAW'(IMG_VEC_N - 1);
  localparam logic [LAW-1:0] COL_LAST = LAW'(LIB_VEC_N - 1);

  state_t                 state_q, state_d;
  logic [IAW-1:0]         row_q, row_d;
  logic [LAW-1:0]         col_q, col_d;
  logic [IAW-1:0]         img_addr_q, img_addr_d;
  logic [LAW-1:0]         lib_addr_q, lib_addr_d;
  logic [VEC_WIDTH-1:0]   img_reg_q, img_reg_d;
  logic [SW-1:0]          out_data_q, out_data_d;
  logic [SW-1:0]          norm_data_q, norm_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   inner_done_q, inner_done_d;
  logic                   outer_done_q, outer_done_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  function automatic logic [SW-1:0] popcount(input logic [VEC_WIDTH-1:0] v);
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < VEC_WIDTH; i++) c = c + SW'(v[i]);
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    img_addr_d   = img_addr_q;
    lib_addr_d   = lib_addr_q;
    img_reg_d    = img_reg_q;
    out_data_d   = out_data_q;
    norm_data_d  = norm_data_q;
    out_valid_d  = out_valid_q;
    inner_done_d = inner_done_q;
    outer_done_d = outer_done_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // the done cycle itself still counts as the tail of the previous pass
        if (start && !done_q) begin
          row_d      = '0;
          col_d      = '0;
          img_addr_d = '0;
          busy_d     = 1'b1;
          state_d    = IMG_A;
        end
      end
      IMG_A: state_d = IMG_D;
      IMG_D: begin
        img_reg_d  = img_rdata;
        lib_addr_d = col_q;
        state_d    = LIB_A;
      end
      LIB_A: state_d = LIB_D;
      LIB_D: begin
        out_data_d   = popcount(~(img_reg_q ^ lib_rdata));
        norm_data_d  = popcount(lib_rdata);
        inner_done_d = (col_q == COL_LAST);
        out_valid_d  = 1'b1;
        state_d      = SEND;
      end
      SEND: begin
        if (nest_ready) begin
          out_valid_d  = 1'b0;
          inner_done_d = 1'b0;
          if (col_q != COL_LAST) begin
            col_d      = col_q + 1'b1;
            lib_addr_d = col_q + 1'b1;
            state_d    = LIB_A;
          end else if (row_q != ROW_LAST) begin
            row_d      = row_q + 1'b1;
            col_d      = '0;
            img_addr_d = row_q + 1'b1;
            state_d    = IMG_A;
          end else begin
            outer_done_d = 1'b1;
            state_d      = OUTER;
          end
        end
      end
      OUTER: begin
        if (nest_ready) begin
          outer_done_d = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      img_addr_q   <= '0;
      lib_addr_q   <= '0;
      img_reg_q    <= '0;
      out_data_q   <= '0;
      norm_data_q  <= '0;
      out_valid_q  <= 1'b0;
      inner_done_q <= 1'b0;
      outer_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      img_addr_q   <= img_addr_d;
      lib_addr_q   <= lib_addr_d;
      img_reg_q    <= img_reg_d;
      out_data_q   <= out_data_d;
      norm_data_q  <= norm_data_d;
      out_valid_q  <= out_valid_d;
      inner_done_q <= inner_done_d;
      outer_done_q <= outer_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign img_addr      = img_addr_q;
  assign lib_addr      = lib_addr_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign norm_data     = norm_data_q;
  assign inner_done    = inner_done_q;
  assign indone_valid  = inner_done_q;
  assign outer_done    = outer_done_q;
  assign outdone_valid = outer_done_q;

endmodule
